// File: rtl/srt_reconstruct_pkg.sv
// Shared definitions for the radix-4 SRT result reconstructor: default sizes
// and the controller state encoding.
package srt_reconstruct_pkg;

  localparam int DEF_DIGITS = 5;
  localparam int DEF_DW     = 6;
  localparam int DEF_RW     = 8;
  localparam int DEF_NW     = 2*DEF_DIGITS + DEF_DW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_ADDR = 2'd2
  } state_t;

endpackage

// File: rtl/srt_digit_mult.sv
// Radix-4 digit times divisor using only shifts and one add; shared with the
// divider's product stage.
module srt_digit_mult #(
  parameter int DW = 6
) (
  input  logic [1:0]    i_digit,
  input  logic [DW-1:0] i_d,
  output logic [DW+1:0] o_prod
);

  logic [DW+1:0] w_d1;
  logic [DW+1:0] w_d2;

  assign w_d1 = {2'b00, i_d};
  assign w_d2 = {1'b0, i_d, 1'b0};

  always_comb begin
    o_prod = '0;
    case (i_digit)
      2'd0: o_prod = '0;
      2'd1: o_prod = w_d1;
      2'd2: o_prod = w_d2;
      2'd3: o_prod = w_d2 + w_d1;
      default: o_prod = '0;
    endcase
  end

endmodule

// File: rtl/srt_reconstruct.sv
// Digit-serial rebuild of the dividend N = Q*D + R, Horner style, MSB digit
// first. Handshake: start is a request sampled only in IDLE; done pulses for
// one cycle when N_out is updated; busy is high from capture until that update.
module srt_reconstruct
  import srt_reconstruct_pkg::*;
#(
  parameter  int DIGITS = DEF_DIGITS,
  parameter  int DW     = DEF_DW,
  parameter  int RW     = DEF_RW,
  localparam int NW     = 2*DIGITS + DW
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [2*DIGITS-1:0] Q,
  input  logic [DW-1:0]       D,
  input  logic [RW-1:0]       R,
  output logic [NW-1:0]       N_out,
  output logic                busy,
  output logic                done,
  output state_t              dbg_state
);

  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t              r_state;
  state_t              w_next;
  logic [2*DIGITS-1:0] r_q;
  logic [DW-1:0]       r_d;
  logic [RW-1:0]       r_r;
  logic [NW-1:0]       r_acc;
  logic [NW-1:0]       r_n;
  logic [CW-1:0]       r_cnt;
  logic                r_busy;
  logic                r_done;
  logic [1:0]          w_digit;
  logic [DW+1:0]       w_prod;
  logic                w_capture;
  logic                w_step;
  logic                w_finish;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:  w_next = start ? S_ACC : S_IDLE;
      S_ACC:   w_next = (r_cnt == '0) ? S_ADDR : S_ACC;
      S_ADDR:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_capture = (r_state == S_IDLE) && start;
    w_step    = (r_state == S_ACC);
    w_finish  = (r_state == S_ADDR);
  end

  // Counter values at or above DIGITS cannot occur, but select digit 0 safely.
  always_comb begin
    w_digit = 2'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_cnt == CW'(i)) w_digit = r_q[2*i +: 2];
    end
  end

  srt_digit_mult #(.DW(DW)) u_mult (
    .i_digit (w_digit),
    .i_d     (r_d),
    .o_prod  (w_prod)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_q    <= '0;
      r_d    <= '0;
      r_r    <= '0;
      r_acc  <= '0;
      r_n    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_capture) begin
        r_q    <= Q;
        r_d    <= D;
        r_r    <= R;
        r_acc  <= '0;
        r_cnt  <= CW'(DIGITS-1);
        r_busy <= 1'b1;
      end
      if (w_step) begin
        r_acc <= (r_acc << 2) + NW'(w_prod);
        if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      end
      if (w_finish) begin
        r_n    <= r_acc + NW'(r_r);
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

  assign N_out     = r_n;
  assign busy      = r_busy;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: doc/srt_reconstruct.md
Name: srt_reconstruct

Overview:
Digit-serial radix-4 reconstructor and checker for the SRT divider result. It takes a 5-digit radix-4 quotient Q, divisor D and remainder R, and rebuilds the dividend as N = Q*D + R.
- Uses Horner accumulation, MSB digit first, one digit per cycle.
- Sits downstream of the divider; a comparator or bench matches the rebuilt N against the original dividend.

Parameters:
DIGITS, 5, number of radix-4 quotient digits (Q width = 2*DIGITS)
DW, 6, divisor width
RW, 8, remainder width
NW, 16, result width; fixed at 2*DIGITS+DW, which also covers the +R term

Ports:
clk  input  1  rising-edge clock
resetn  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
Q  input  2*DIGITS  quotient; digit i = Q[2i+1:2i], unsigned 0..3
D  input  DW  divisor, unsigned
R  input  RW  remainder, unsigned
N_out  output  NW  reconstructed dividend; holds its value until the next accepted start
busy  output  1  high while a reconstruction is in progress
done  output  1  one-cycle pulse when N_out becomes valid

Behaviour:
- Reset (asynchronous, resetn=0):
  - State=IDLE; acc, N_out, busy, done, digit counter and captured operands all go to 0.
  - This applies immediately, including mid-operation; no partial result survives.
- States: IDLE -> ACC -> ADDR -> IDLE.
- IDLE:
  - done is low except in the cycle immediately after ADDR.
  - On start=1 at edge k: capture Q, D, R; clear acc; counter=DIGITS-1; busy=1; go to ACC.
- ACC, edges k+1..k+DIGITS:
  - acc <= (acc<<2) + digit[counter]*D, then counter decrements.
  - When counter==0, the next state is ADDR.
- ADDR, edge k+DIGITS+1:
  - N_out <= acc + R (zero-extended), busy <= 0, done <= 1, go to IDLE.
- done is cleared at the following edge unless a new result completes.
- Latency: done is high in the cycle after edge k+6 for the default parameters.
- start while busy=1 is ignored; operands are not re-captured.
- start in the cycle where done=1 is accepted (state is IDLE), so back-to-back ops take 7 cycles each.
- Input changes after capture do not affect the in-flight result.
- Arithmetic: all operations are unsigned, mod 2^NW.
  - The max case (Q=all 3s, D=2^DW-1, R=2^RW-1) fits without overflow.
  - No overflow flag.
- digit*D is formed by shift/add: 0, D, D<<1, (D<<1)+D. No general multiplier.
- No X propagation: every state/digit combination is fully specified; the default state is IDLE.

Decomposition:
- Shared package: state encoding (IDLE, ACC, ADDR), DIGITS/DW/RW defaults, NW derivation.
- One sub-module: srt_digit_mult, combinational, mapping (digit[1:0], D[DW-1:0]) -> digit*D [DW+1:0]. It is reusable by the divider's product stage.
- Top level: FSM, counter, operand capture registers, accumulator, output register.

Test Plan:
- Basic case: Q=10'b0000000001, D=32, R=5, start pulse -> busy high 6 cycles, done pulse after edge k+6, N_out=37.
- Max operands: Q=10'h3FF, D=63, R=255 -> N_out=64704 (16'hFCC0), no wrap.
- All-2 digits: Q=10'h2AA, D=16, R=0 -> N_out=10912 (16'h2AA0). Also change Q/D/R after start -> result unchanged.
- Start while busy: start asserted at edges k+2 and k+4 with different operands -> ignored; first result is correct, and busy/done timing is unchanged.
- Reset mid-operation: resetn low during ACC (edge k+3) -> N_out=0, busy=0, done=0 immediately. After release, a new start with Q=10'h001, D=1, R=0 gives N_out=1.
- Back-to-back: second start in the done cycle (Q=10'h155, D=3, R=2) -> accepted, done again 7 cycles later, N_out=1025.
